// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and stage index width.
package reset_seq_pkg;

  localparam int MAX_STAGES = 8;
  localparam int STAGE_W    = 3;

  typedef logic [STAGE_W-1:0] stage_idx_t;

  typedef enum logic [2:0] {
    S_POR,
    S_DELAY,
    S_LOCK,
    S_RUN,
    S_FAULT
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / soft-reset sequencer: releases active-low reset domains in order,
// optionally waiting for a per-stage lock, with timeout fault and lock-loss restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                    NUM_STAGES  = 4,
  parameter int                    CNT_W       = 12,
  parameter int                    POR_CYCLES  = 4095,
  parameter int                    STAGE_DELAY = 16,
  parameter int                    TIMEOUT     = 4000,
  parameter logic [NUM_STAGES-1:0] LOCK_MASK   = NUM_STAGES'(1)
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  soft_rst_req_i,
  input  logic [NUM_STAGES-1:0] lock_i,
  output logic [NUM_STAGES-1:0] reset_n_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [2:0]            stage_o,
  output logic                  lock_lost_o
);

  localparam int MAX_WAIT_A = (POR_CYCLES > STAGE_DELAY) ? POR_CYCLES : STAGE_DELAY;
  localparam int MAX_WAIT   = (MAX_WAIT_A > TIMEOUT) ? MAX_WAIT_A : TIMEOUT;
  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES must be in 1..%0d", MAX_STAGES);
  end
  if (POR_CYCLES < 1 || STAGE_DELAY < 1 || TIMEOUT < 1) begin : g_bad_counts
    $error("reset_sequencer: POR_CYCLES, STAGE_DELAY and TIMEOUT must be >= 1");
  end
  if (CNT_RANGE <= longint'(MAX_WAIT)) begin : g_bad_cnt_w
    $error("reset_sequencer: CNT_W too narrow for the largest wait");
  end

  // S_POR leaves on the edge after the count reaches POR_CYCLES, which together with
  // the STAGE_DELAY count gives POR_CYCLES+STAGE_DELAY+1 edges to the first release.
  localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam stage_idx_t       LAST_STAGE   = stage_idx_t'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d, timer_inc;
  stage_idx_t            stage_q, stage_d;
  logic [NUM_STAGES-1:0] released_q, released_d;
  logic [NUM_STAGES-1:0] lock_s;
  logic [NUM_STAGES-1:0] stage_sel;
  logic                  lock_lost_d, lock_lost_q;
  logic                  busy_d, busy_q;
  logic                  fault_d, fault_q;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .reset (reset_i),
      .d     (lock_i[k]),
      .q     (lock_s[k])
    );
  end

  always_comb begin
    stage_sel = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == stage_idx_t'(k)) stage_sel[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= S_POR;
      timer_q     <= '0;
      stage_q     <= '0;
      released_q  <= '0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stage_q     <= stage_d;
      released_q  <= released_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Soft request outranks lock loss, which outranks timeout, which outranks advance.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stage_d     = stage_q;
    released_d  = released_q;
    lock_lost_d = 1'b0;
    timer_inc   = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    if (soft_rst_req_i && state_q != S_POR) begin
      state_d    = S_DELAY;
      timer_d    = '0;
      stage_d    = '0;
      released_d = '0;
    end else begin
      case (state_q)
        S_POR: begin
          if (timer_q == POR_LAST) begin
            state_d = S_DELAY;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_DELAY: begin
          if (timer_q == DELAY_LAST) begin
            released_d = released_q | stage_sel;
            timer_d    = '0;
            if (|(stage_sel & LOCK_MASK)) begin
              state_d = S_LOCK;
            end else if (stage_q == LAST_STAGE) begin
              state_d = S_RUN;
            end else begin
              stage_d = stage_q + stage_idx_t'(1);
            end
          end else begin
            timer_d = timer_inc;
          end
        end
        S_LOCK: begin
          if (timer_q == TIMEOUT_LAST) begin
            state_d    = S_FAULT;
            released_d = '0;
            timer_d    = '0;
          end else if (|(stage_sel & lock_s)) begin
            timer_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DELAY;
              stage_d = stage_q + stage_idx_t'(1);
            end
          end else begin
            timer_d = timer_inc;
          end
        end
        S_RUN: begin
          if (|(LOCK_MASK & ~lock_s)) begin
            lock_lost_d = 1'b1;
            state_d     = S_DELAY;
            timer_d     = '0;
            stage_d     = '0;
            released_d  = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d    = S_POR;
          timer_d    = '0;
          stage_d    = '0;
          released_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_d  = (state_d != S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  assign reset_n_o   = released_q;
  assign busy_o      = busy_q;
  assign fault_o     = fault_q;
  assign stage_o     = stage_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short POR/delay/timeout values; edge
// numbers in each task count from the first edge that samples the new input level.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       soft_rst_req_i = 1'b0;
  logic [3:0] lock_i = 4'b0000;
  logic [3:0] reset_n_o;
  logic       busy_o;
  logic       fault_o;
  logic [2:0] stage_o;
  logic       lock_lost_o;

  int compared = 0;
  int mismatched = 0;

  reset_sequencer #(
    .NUM_STAGES  (4),
    .CNT_W       (12),
    .POR_CYCLES  (4),
    .STAGE_DELAY (3),
    .TIMEOUT     (10),
    .LOCK_MASK   (4'b0001)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .soft_rst_req_i (soft_rst_req_i),
    .lock_i         (lock_i),
    .reset_n_o      (reset_n_o),
    .busy_o         (busy_o),
    .fault_o        (fault_o),
    .stage_o        (stage_o),
    .lock_lost_o    (lock_lost_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_reach_run busy_o got %b expected 0 within 40 edges", tag, busy_o);
    end
    compared++;
    if (reset_n_o !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL %s_run_released reset_n_o got %b expected 1111", tag, reset_n_o);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rn;
    lock_i = 4'b0001;
    soft_rst_req_i = 1'b0;
    reset_i = 1'b1;
    tick();
    tick();
    compared++;
    if (reset_n_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_rn got %b expected 0000", reset_n_o); end
    compared++;
    if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_busy got %b expected 1", busy_o); end
    compared++;
    if (fault_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault got %b expected 0", fault_o); end
    compared++;
    if (stage_o !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_stage got %0d expected 0", stage_o); end
    compared++;
    if (lock_lost_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_lock_lost got %b expected 0", lock_lost_o); end
    reset_i = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_rn = 4'b0000;
      if (e >= 8)  exp_rn[0] = 1'b1;
      if (e >= 12) exp_rn[1] = 1'b1;
      if (e >= 15) exp_rn[2] = 1'b1;
      if (e >= 18) exp_rn[3] = 1'b1;
      compared++;
      if (reset_n_o !== exp_rn) begin
        mismatched++;
        $display("[TB] FAIL power_up_e%0d reset_n_o got %b expected %b", e, reset_n_o, exp_rn);
      end
      if (e == 10) begin
        compared++;
        if (stage_o !== 3'd1) begin mismatched++; $display("[TB] FAIL power_up_stage_e10 got %0d expected 1", stage_o); end
      end
      if (e == 17) begin
        compared++;
        if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL power_up_busy_e17 got %b expected 1", busy_o); end
      end
      if (e == 18) begin
        compared++;
        if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL power_up_busy_e18 got %b expected 0", busy_o); end
        compared++;
        if (stage_o !== 3'd3) begin mismatched++; $display("[TB] FAIL power_up_stage_e18 got %0d expected 3", stage_o); end
      end
    end
  endtask

  task automatic test_timeout();
    lock_i = 4'b0000;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 8 || e == 17) begin
        compared++;
        if (reset_n_o !== 4'b0001) begin mismatched++; $display("[TB] FAIL timeout_rn_e%0d got %b expected 0001", e, reset_n_o); end
        compared++;
        if (fault_o !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_fault_e%0d got %b expected 0", e, fault_o); end
      end
      if (e == 18 || e == 22) begin
        compared++;
        if (fault_o !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_fault_e%0d got %b expected 1", e, fault_o); end
        compared++;
        if (reset_n_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL timeout_rn_e%0d got %b expected 0000", e, reset_n_o); end
        compared++;
        if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_busy_e%0d got %b expected 1", e, busy_o); end
      end
    end
  endtask

  task automatic test_soft_restart();
    lock_i = 4'b0001;
    tick();
    tick();
    tick();
    compared++;
    if (fault_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fault_sticky got %b expected 1", fault_o); end
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    compared++;
    if (fault_o !== 1'b0) begin mismatched++; $display("[TB] FAIL soft_fault_clear got %b expected 0", fault_o); end
    compared++;
    if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL soft_busy got %b expected 1", busy_o); end
    tick();
    tick();
    compared++;
    if (reset_n_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL soft_rn_e3 got %b expected 0000", reset_n_o); end
    tick();
    compared++;
    if (reset_n_o !== 4'b0001) begin mismatched++; $display("[TB] FAIL soft_rn_e4 got %b expected 0001", reset_n_o); end
    wait_run("soft");
  endtask

  task automatic test_lock_lost();
    lock_i = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e <= 2) begin
        compared++;
        if (lock_lost_o !== 1'b0 || reset_n_o !== 4'b1111) begin
          mismatched++;
          $display("[TB] FAIL lock_lost_early_e%0d got pulse %b rn %b expected 0 1111", e, lock_lost_o, reset_n_o);
        end
      end
      if (e == 3) begin
        compared++;
        if (lock_lost_o !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_lost_pulse got %b expected 1", lock_lost_o); end
        compared++;
        if (reset_n_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL lock_lost_rn got %b expected 0000", reset_n_o); end
        compared++;
        if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL lock_lost_busy got %b expected 1", busy_o); end
        lock_i = 4'b0001;
      end
      if (e == 4) begin
        compared++;
        if (lock_lost_o !== 1'b0) begin mismatched++; $display("[TB] FAIL lock_lost_one_cycle got %b expected 0", lock_lost_o); end
      end
      if (e == 6) begin
        compared++;
        if (reset_n_o !== 4'b0001) begin mismatched++; $display("[TB] FAIL lock_lost_reseq_rn got %b expected 0001", reset_n_o); end
      end
    end
    wait_run("lock_lost");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    while (stage_o !== 3'd2 && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (stage_o !== 3'd2 || reset_n_o !== 4'b0011) begin
      mismatched++;
      $display("[TB] FAIL mid_reach_stage2 got stage %0d rn %b expected 2 0011", stage_o, reset_n_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    compared++;
    if (reset_n_o !== 4'b0000 || stage_o !== 3'd0 || busy_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_drop got rn %b stage %0d busy %b expected 0000 0 1", reset_n_o, stage_o, busy_o);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      soft_rst_req_i = (e == 2);
      compared++;
      if (reset_n_o !== ((e >= 8) ? 4'b0001 : 4'b0000)) begin
        mismatched++;
        $display("[TB] FAIL mid_por_e%0d reset_n_o got %b expected %b", e, reset_n_o, (e >= 8) ? 4'b0001 : 4'b0000);
      end
    end
    soft_rst_req_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    reset_i = 1'b1;
    soft_rst_req_i = 1'b1;
    tick();
    reset_i = 1'b0;
    soft_rst_req_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3 || e == 7 || e == 8) begin
        compared++;
        if (reset_n_o !== ((e == 8) ? 4'b0001 : 4'b0000)) begin
          mismatched++;
          $display("[TB] FAIL simul_por_e%0d reset_n_o got %b expected %b", e, reset_n_o, (e == 8) ? 4'b0001 : 4'b0000);
        end
      end
    end
    wait_run("simul");
  endtask

  task automatic test_soft_level();
    soft_rst_req_i = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      compared++;
      if (reset_n_o !== 4'b0000 || stage_o !== 3'd0 || busy_o !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL soft_level_e%0d got rn %b stage %0d busy %b expected 0000 0 1", e, reset_n_o, stage_o, busy_o);
      end
    end
    soft_rst_req_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      compared++;
      if (reset_n_o !== ((e == 3) ? 4'b0001 : 4'b0000)) begin
        mismatched++;
        $display("[TB] FAIL soft_level_release_e%0d got %b expected %b", e, reset_n_o, (e == 3) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_soft_restart();
    test_lock_lost();
    test_reset_mid();
    test_simultaneous();
    test_soft_level();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
